// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   NOP_INST        canonical RV32I NOP (addi x0, x0, 0)
//   fetch_state_e   fetch FSM encodings (REQ / WAIT / DROP)
//   *_LSB / *_MSB   instruction field bit positions used for predecode
//   inst_opcode/inst_rs1/inst_rs2  field extractors
package fetch_stage_pkg;

  localparam logic [6:0]  OPC_OP_IMM = 7'h13;
  localparam logic [31:0] NOP_INST   = {25'd0, OPC_OP_IMM};

  localparam int unsigned OPC_LSB = 0;
  localparam int unsigned OPC_MSB = 6;
  localparam int unsigned RS1_LSB = 15;
  localparam int unsigned RS1_MSB = 19;
  localparam int unsigned RS2_LSB = 20;
  localparam int unsigned RS2_MSB = 24;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  function automatic logic [6:0] inst_opcode(input logic [31:0] inst);
    return inst[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [4:0] inst_rs1(input logic [31:0] inst);
    return inst[RS1_MSB:RS1_LSB];
  endfunction

  function automatic logic [4:0] inst_rs2(input logic [31:0] inst);
    return inst[RS2_MSB:RS2_LSB];
  endfunction

endpackage

// File: rtl/fetch_resp_buf.sv
// One-entry instruction + PC holding buffer for the fetch stage.
// Catches a response that lands while IF/ID is stalled.
//   clk_i, rst_n_i  clock, asynchronous active-low reset
//   load_i          capture inst_i/pc_i and mark the entry valid
//   clear_i         drop the entry (wins over load_i)
//   inst_i, pc_i    word and its fetch PC
//   valid_o, inst_o, pc_o  buffered entry
module fetch_resp_buf
  import fetch_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            load_i,
  input  logic            clear_i,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            valid_o,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] pc_o
);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_o <= 1'b0;
      inst_o  <= NOP_INST;
      pc_o    <= '0;
    end else if (clear_i) begin
      valid_o <= 1'b0;
    end else if (load_i) begin
      valid_o <= 1'b1;
      inst_o  <= inst_i;
      pc_o    <= pc_i;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register of the RV32I core.
// Owns the PC, keeps at most one request outstanding to instruction memory,
// absorbs hazard stalls and EX flush/redirects, and presents the IF/ID
// instruction with predecoded opcode/rs1/rs2.
//   clk_i, rst_n_i           clock, asynchronous active-low reset
//   stall_i                  hold IF/ID and PC
//   flush_i, redirect_pc_i   kill younger instructions, restart at target
//   imem_req_o/addr_o        fetch request and address
//   imem_gnt_i               request accepted this cycle
//   imem_rvalid_i/rdata_i    response valid and instruction word
//   if_valid_o/pc_o/inst_o   IF/ID contents (NOP when invalid)
//   if_opcode_o/rs1_o/rs2_o  predecoded fields of if_inst_o
//   perf_stall_cnt_o, perf_bubble_cnt_o
//                            saturating counters, built only when
//                            FETCH_PERF_CNT_EN is defined; else tied to 0
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            if_valid_o,
  output logic [XLEN-1:0] if_pc_o,
  output logic [31:0]     if_inst_o,
  output logic [6:0]      if_opcode_o,
  output logic [4:0]      if_rs1_o,
  output logic [4:0]      if_rs2_o,
  output logic [31:0]     perf_stall_cnt_o,
  output logic [31:0]     perf_bubble_cnt_o
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            run_q;
  logic            req, fire, resp_valid;
  logic            buf_load, buf_clear, buf_valid;
  logic [31:0]     buf_inst;
  logic [XLEN-1:0] buf_pc;
  logic [XLEN-1:0] redirect_pc;
  logic            if_valid_q;
  logic [XLEN-1:0] if_pc_q;
  logic [31:0]     if_inst_q;

  assign redirect_pc = {redirect_pc_i[XLEN-1:2], 2'b00};

  // Holds the request low for the first cycle out of reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) run_q <= 1'b0;
    else          run_q <= 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    req        = 1'b0;
    resp_valid = 1'b0;
    fire       = 1'b0;

    unique case (state_q)
      REQ:  req = run_q && !buf_valid;
      // The next request goes out in the same cycle the previous response
      // lands straight into IF/ID, giving one instruction per cycle while
      // still never having two requests in flight across a clock edge.
      WAIT: begin
        resp_valid = imem_rvalid_i;
        req        = imem_rvalid_i && !stall_i && !flush_i;
      end
      DROP: req = 1'b0;
      default: req = 1'b0;
    endcase

    fire = req && imem_gnt_i;
    if (fire) begin
      pc_d     = pc_q + XLEN'(4);
      req_pc_d = pc_q;
    end

    unique case (state_q)
      REQ:  if (fire) state_d = WAIT;
      WAIT: if (imem_rvalid_i) state_d = fire ? WAIT : REQ;
      DROP: if (imem_rvalid_i) state_d = REQ;
      default: state_d = REQ;
    endcase

    if (flush_i) begin
      pc_d = redirect_pc;
      unique case (state_q)
        REQ:     state_d = fire ? DROP : REQ;
        WAIT:    state_d = imem_rvalid_i ? REQ : DROP;
        DROP:    state_d = imem_rvalid_i ? REQ : DROP;
        default: state_d = REQ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  assign buf_load  = resp_valid && stall_i && !flush_i;
  assign buf_clear = flush_i || (!stall_i && buf_valid);

  fetch_resp_buf #(.XLEN(XLEN)) u_resp_buf (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load_i  (buf_load),
    .clear_i (buf_clear),
    .inst_i  (imem_rdata_i),
    .pc_i    (req_pc_q),
    .valid_o (buf_valid),
    .inst_o  (buf_inst),
    .pc_o    (buf_pc)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_inst_q  <= NOP_INST;
    end else if (flush_i) begin
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_inst_q  <= NOP_INST;
    end else if (stall_i) begin
      if_valid_q <= if_valid_q;
    end else if (buf_valid) begin
      if_valid_q <= 1'b1;
      if_pc_q    <= buf_pc;
      if_inst_q  <= buf_inst;
    end else if (resp_valid) begin
      if_valid_q <= 1'b1;
      if_pc_q    <= req_pc_q;
      if_inst_q  <= imem_rdata_i;
    end else begin
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_inst_q  <= NOP_INST;
    end
  end

  assign imem_req_o  = req;
  assign imem_addr_o = pc_q;
  assign if_valid_o  = if_valid_q;
  assign if_pc_o     = if_pc_q;
  assign if_inst_o   = if_inst_q;
  assign if_opcode_o = inst_opcode(if_inst_q);
  assign if_rs1_o    = inst_rs1(if_inst_q);
  assign if_rs2_o    = inst_rs2(if_inst_q);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q, bubble_cnt_q;
  logic        starve;

  // Bubble caused by memory starvation, not by a redirect.
  assign starve = !flush_i && !stall_i && !buf_valid && !resp_valid;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (stall_i && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (starve && (bubble_cnt_q != '1)) bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt_o  = stall_cnt_q;
  assign perf_bubble_cnt_o = bubble_cnt_q;
`else
  assign perf_stall_cnt_o  = '0;
  assign perf_bubble_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        stall, flush;
  logic [31:0] redir;
  logic        req, gnt, rvalid;
  logic [31:0] addr, rdata;
  logic        if_valid;
  logic [31:0] if_pc, if_inst;
  logic [6:0]  opc;
  logic [4:0]  rs1, rs2;
  logic [31:0] pstall, pbub;

  // memory model controls
  logic        gnt_en;
  int unsigned lat;
  logic        pend;
  logic [31:0] paddr;
  int unsigned cnt;
  int          proto_err = 0;

  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk_i             (clk),
    .rst_n_i           (rst_n),
    .stall_i           (stall),
    .flush_i           (flush),
    .redirect_pc_i     (redir),
    .imem_req_o        (req),
    .imem_addr_o       (addr),
    .imem_gnt_i        (gnt),
    .imem_rvalid_i     (rvalid),
    .imem_rdata_i      (rdata),
    .if_valid_o        (if_valid),
    .if_pc_o           (if_pc),
    .if_inst_o         (if_inst),
    .if_opcode_o       (opc),
    .if_rs1_o          (rs1),
    .if_rs2_o          (rs2),
    .perf_stall_cnt_o  (pstall),
    .perf_bubble_cnt_o (pbub)
  );

  function automatic logic [31:0] inst_for(input logic [31:0] a);
    return {a[19:0], 5'd1, (a[2] ? 7'h33 : 7'h13)};
  endfunction

  assign gnt    = req && gnt_en;
  assign rvalid = pend && (cnt == 0);
  assign rdata  = rvalid ? inst_for(paddr) : 32'hDEAD_BEEF;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend  <= 1'b0;
      cnt   <= 0;
      paddr <= '0;
    end else begin
      if (req && gnt && pend && !rvalid) proto_err <= proto_err + 1;
      if (req && gnt) begin
        pend  <= 1'b1;
        paddr <= addr;
        cnt   <= lat;
      end else if (rvalid) begin
        pend <= 1'b0;
      end else if (pend) begin
        cnt <= cnt - 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst req", 32'(req), 32'd0);
    check("rst addr", addr, 32'h0);
    check("rst valid", 32'(if_valid), 32'd0);
    check("rst pc", if_pc, 32'h0);
    check("rst inst", if_inst, NOP);
    check("rst opcode", 32'(opc), 32'h13);
    check("rst rs1", 32'(rs1), 32'd0);
    check("rst rs2", 32'(rs2), 32'd0);
    check("rst perf_stall", pstall, 32'd0);
    check("rst perf_bubble", pbub, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit          rst;
    bit          stall;
    bit          flush;
    logic [31:0] redir;
    bit          gnt;
    int unsigned lat;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit r, input bit s, input bit f, input logic [31:0] rd,
                     input bit g, input int unsigned l, input bit er,
                     input logic [31:0] ea, input bit ev, input logic [31:0] ep);
    vec_t t;
    t.rst = r; t.stall = s; t.flush = f; t.redir = rd; t.gnt = g; t.lat = l;
    t.e_req = er; t.e_addr = ea; t.e_valid = ev; t.e_pc = ep;
    vecs.push_back(t);
  endtask

  vec_t        v;
  logic [31:0] exp_inst;

  initial begin
    rst_n  = 1'b1;
    stall  = 1'b0;
    flush  = 1'b0;
    redir  = '0;
    gnt_en = 1'b1;
    lat    = 0;

    // streaming, then a 3-cycle stall while the 0x10 response arrives
    add(1,0,0,0,1,0, 0,'h0,0,0);
    add(0,0,0,0,1,0, 1,'h0,0,0);
    add(0,0,0,0,1,0, 1,'h4,0,0);
    add(0,0,0,0,1,0, 1,'h8,1,'h0);
    add(0,0,0,0,1,0, 1,'hC,1,'h4);
    add(0,0,0,0,1,0, 1,'h10,1,'h8);
    add(0,1,0,0,1,0, 0,'h14,1,'hC);
    add(0,1,0,0,1,0, 0,'h14,1,'hC);
    add(0,1,0,0,1,0, 0,'h14,1,'hC);
    add(0,0,0,0,1,0, 0,'h14,1,'hC);
    add(0,0,0,0,1,0, 1,'h14,1,'h10);
    add(0,0,0,0,1,0, 1,'h18,0,0);
    add(0,0,0,0,1,0, 1,'h1C,1,'h14);
    add(0,0,0,0,1,0, 1,'h20,1,'h18);
    // flush in WAIT without rvalid (redirect low bits forced to 0)
    add(1,0,0,0,1,0, 0,'h0,0,0);
    add(0,0,0,0,1,0, 1,'h0,0,0);
    add(0,0,0,0,1,2, 1,'h4,0,0);
    add(0,0,1,'h202,1,0, 0,'h8,1,'h0);
    add(0,0,0,0,1,0, 0,'h200,0,0);
    add(0,0,0,0,1,0, 0,'h200,0,0);
    add(0,0,0,0,1,0, 1,'h200,0,0);
    add(0,0,0,0,1,0, 1,'h204,0,0);
    add(0,0,0,0,1,0, 1,'h208,1,'h200);
    // flush together with stall while the buffer is full
    add(1,0,0,0,1,0, 0,'h0,0,0);
    add(0,0,0,0,1,0, 1,'h0,0,0);
    add(0,0,0,0,1,0, 1,'h4,0,0);
    add(0,0,0,0,1,0, 1,'h8,1,'h0);
    add(0,1,0,0,1,0, 0,'hC,1,'h4);
    add(0,1,1,'h100,1,0, 0,'hC,1,'h4);
    add(0,0,0,0,1,0, 1,'h100,0,0);
    add(0,0,0,0,1,0, 1,'h104,0,0);
    add(0,0,0,0,1,0, 1,'h108,1,'h100);
    // grant withheld 4 cycles with a flush in the middle
    add(1,0,0,0,0,0, 0,'h0,0,0);
    add(0,0,0,0,0,0, 1,'h0,0,0);
    add(0,0,0,0,0,0, 1,'h0,0,0);
    add(0,0,1,'h40,0,0, 1,'h0,0,0);
    add(0,0,0,0,0,0, 1,'h40,0,0);
    add(0,0,0,0,1,0, 1,'h40,0,0);
    add(0,0,0,0,1,0, 1,'h44,0,0);
    add(0,0,0,0,1,0, 1,'h48,1,'h40);
    // flush with gnt in REQ, flush with rvalid in WAIT, PC wrap
    add(1,0,0,0,1,0, 0,'h0,0,0);
    add(0,0,1,'h80,1,0, 1,'h0,0,0);
    add(0,0,0,0,1,0, 0,'h80,0,0);
    add(0,0,0,0,1,0, 1,'h80,0,0);
    add(0,0,1,'h300,1,0, 0,'h84,0,0);
    add(0,0,0,0,1,0, 1,'h300,0,0);
    add(0,0,0,0,1,0, 1,'h304,0,0);
    add(0,0,1,'hFFFF_FFFC,1,0, 0,'h308,1,'h300);
    add(0,0,0,0,1,0, 1,'hFFFF_FFFC,0,0);
    add(0,0,0,0,1,0, 1,'h0,0,0);
    add(0,0,0,0,1,0, 1,'h4,1,'hFFFF_FFFC);

    #2;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      if (v.rst) do_reset();
      stall  = v.stall;
      flush  = v.flush;
      redir  = v.redir;
      gnt_en = v.gnt;
      lat    = v.lat;
      #1;
      check($sformatf("row%0d req", i), 32'(req), 32'(v.e_req));
      check($sformatf("row%0d addr", i), addr, v.e_addr);
      check($sformatf("row%0d valid", i), 32'(if_valid), 32'(v.e_valid));
      if (v.e_valid) begin
        exp_inst = inst_for(v.e_pc);
        check($sformatf("row%0d pc", i), if_pc, v.e_pc);
        check($sformatf("row%0d inst", i), if_inst, exp_inst);
        check($sformatf("row%0d opcode", i), 32'(opc), 32'(exp_inst[6:0]));
        check($sformatf("row%0d rs1", i), 32'(rs1), 32'(exp_inst[19:15]));
        check($sformatf("row%0d rs2", i), 32'(rs2), 32'(exp_inst[24:20]));
      end else begin
        check($sformatf("row%0d nop", i), if_inst, NOP);
      end
      @(posedge clk);
      #1;
    end

    // reset while a request is in flight, then 5 stall + 2 starved cycles
    stall  = 1'b1;
    flush  = 1'b0;
    gnt_en = 1'b0;
    do_reset();
    repeat (5) begin @(posedge clk); #1; end
    stall = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
`ifdef FETCH_PERF_CNT_EN
    check("perf stall", pstall, 32'd5);
    check("perf bubble", pbub, 32'd2);
`else
    check("perf stall", pstall, 32'd0);
    check("perf bubble", pbub, 32'd0);
`endif
    gnt_en = 1'b1;
    lat    = 0;
    #1;
    check("post-rst req", 32'(req), 32'd1);
    check("post-rst addr", addr, 32'h0);
    @(posedge clk); #1;
    check("post-rst addr2", addr, 32'h4);
    check("post-rst valid0", 32'(if_valid), 32'd0);
    @(posedge clk); #1;
    check("post-rst valid", 32'(if_valid), 32'd1);
    check("post-rst pc", if_pc, 32'h0);
    check("post-rst inst", if_inst, inst_for(32'h0));

    check("single outstanding", 32'(proto_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
